audio_framer: RTL and testbench
===============================

# audio_framer

Front-end stage feeding the MFCC pipeline. Applies fixed-point pre-emphasis to the raw 16-bit audio stream and stores the result in a circular buffer. Emits overlapping frames of FRAME_LEN samples every HOP samples as a valid/ready burst. The FFT/MFCC stage consumes each burst as one analysis window.

## Interface
- FRAME_LEN, 256, samples per frame; power of two, ≥ 8
- HOP, 128, new samples between frame starts; 1 ≤ HOP ≤ FRAME_LEN
- ALPHA_SHIFT, 5, pre-emphasis alpha = 1 − 2^-ALPHA_SHIFT; range 1..8
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- sample_in  in  16  signed audio sample
- sample_valid  in  1  one-cycle qualifier for sample_in; no backpressure
- frame_data  out  16  signed pre-emphasised sample
- frame_valid  out  1  frame_data valid
- frame_ready  in  1  downstream accepts the beat when valid && ready
- frame_index  out  log2(FRAME_LEN)  beat position within the frame, 0..FRAME_LEN−1
- frame_last  out  1  high on beat FRAME_LEN−1
- frame_err  out  1  one-cycle pulse when a frame is aborted
- drop_count  out  16  saturating count of frames dropped because the block was busy

## Operation
- Pre-emphasis: y = x[n] − x[n−1] + (x[n−1] >>> ALPHA_SHIFT).
  - Arithmetic shift, floor toward −inf.
  - Computed in 18-bit signed, then saturated to [−32768, 32767].
  - x[−1] = 0 after reset; only accepted samples update x[n−1].
- Buffer: depth 2·FRAME_LEN, synchronous RAM, write pointer wr_ptr, wraps modulo the depth.
- Sample counter: counts writes since reset.
  - The first frame is due on write number FRAME_LEN.
  - Subsequent frames are due every HOP writes after that.
  - A frame covers the FRAME_LEN most recent writes, oldest first.
- FSM states:
  - IDLE: wait for a due frame. On frame due, set rd_ptr = wr_ptr_after_write − FRAME_LEN and go to PREFETCH.
  - PREFETCH: one cycle for the RAM read, then go to STREAM.
  - STREAM: present beats. On each accepted beat, advance rd_ptr and frame_index. After the accepted beat with frame_last, go to IDLE.
- Frame due while not IDLE: the frame is dropped, drop_count increments (saturating at 65535), and the current frame continues.
- Overwrite guard: a write occurring in PREFETCH/STREAM with wr_ptr == rd_ptr (the next unread sample would be overwritten) aborts the frame.
  - The write still happens.
  - frame_err pulses for one cycle, frame_valid drops the following cycle, FSM goes to IDLE.
  - A partial frame never ends with frame_last.
- Simultaneous abort and frame due in the same cycle: the abort wins. The due frame starts from IDLE on the next cycle and is not counted as dropped.
- frame_data/frame_index/frame_last are registered. While frame_valid && !frame_ready they hold stable. frame_valid never drops without acceptance except on abort.

## Timing
- Reset (async assert, sync release) values:
  - frame_valid = 0, frame_last = 0, frame_err = 0
  - frame_data = 0, frame_index = 0, drop_count = 0
  - wr_ptr = 0, sample counter = 0, x[n−1] = 0, FSM = IDLE
  - Buffer contents are don't-care.
- Reset mid-frame: outputs return to reset values immediately; no partial frame resumes.
- Pre-emphasis: register captures y at the end of cycle t (sample_valid in t). RAM write occurs at the end of t+1.
- Frame start latency: when the sample in cycle t makes a frame due, frame_valid first asserts in cycle t+3 with frame_index = 0.
- Throughput: one beat per cycle while frame_ready is held high. A full frame takes FRAME_LEN cycles after the first beat.
- sample_valid may be high every cycle. Data and pointers stay correct at that rate; only frame drops or aborts can result.

## Test plan
(FRAME_LEN=8, HOP=4, ALPHA_SHIFT=5, frame_ready=1 unless stated.)
- Pre-emphasis: constant 1000 ×8 -> first frame = 1000, 31, 31, 31, 31, 31, 31, 31. Constant −1000 -> −1000, then −32 repeated.
- Saturation: −32768 then 32767 -> second output 32767. 32767 then −32768 -> −32768.
- Framing: ramp 1..16, one sample every 20 cycles.
  - Frames start after samples 8, 12 and 16.
  - Frame 2 is the emphasised samples 5..12.
  - frame_last is on index 7, and frame_valid appears exactly 3 cycles after the due sample.
- Backpressure: toggle frame_ready 1/0 each cycle -> data/index held while stalled; all 8 beats delivered in order, none duplicated.
- Drop: frame_ready=0 for 40 cycles while samples arrive every 8 cycles -> drop_count increments per due frame. If wr_ptr reaches rd_ptr: frame_err pulse, no frame_last, recovery on next due frame.
- Reset mid-STREAM: assert rst_n=0 at beat 3 -> frame_valid=0 and drop_count=0 at once. After release, the first frame appears after 8 new samples.

Source files
------------

// File: rtl/audio_framer_if.sv
// audio_framer_if
//   Groups the sample input stream and the frame output burst of the
//   audio framer into one bundle.
//
//   Sample side : sample_in (signed 16), sample_valid (one-cycle qualifier,
//                 no backpressure).
//   Frame side  : frame_data (signed 16), frame_valid, frame_ready,
//                 frame_index, frame_last, frame_err (abort pulse),
//                 drop_count (saturating count of dropped frames).
//
//   Handshake: a frame beat transfers on a rising clock edge where
//   frame_valid && frame_ready are both high. Once frame_valid is raised,
//   frame_data/frame_index/frame_last hold stable until the beat transfers;
//   the only exception is an abort, signalled by frame_err, after which
//   frame_valid drops without a transfer.
//
//   Modports: slave  = the framer itself
//             master = the environment (sample source + frame consumer)
interface audio_framer_if #(
  parameter int FRAME_LEN = 256
);
  localparam int IDX_W = $clog2(FRAME_LEN);

  logic [15:0]      sample_in;
  logic             sample_valid;
  logic [15:0]      frame_data;
  logic             frame_valid;
  logic             frame_ready;
  logic [IDX_W-1:0] frame_index;
  logic             frame_last;
  logic             frame_err;
  logic [15:0]      drop_count;

  modport master (
    output sample_in, sample_valid, frame_ready,
    input  frame_data, frame_valid, frame_index, frame_last, frame_err,
           drop_count
  );

  modport slave (
    input  sample_in, sample_valid, frame_ready,
    output frame_data, frame_valid, frame_index, frame_last, frame_err,
           drop_count
  );
endinterface

// File: rtl/audio_framer.sv
// audio_framer
//   Pre-emphasises a raw 16-bit audio stream (y = x[n] - x[n-1] + x[n-1]>>>S),
//   stores the result in a circular buffer of 2*FRAME_LEN entries and emits
//   overlapping frames of FRAME_LEN samples every HOP samples as a
//   valid/ready burst.
//
//   Ports:
//     clk        : single clock, rising edge
//     rst_n      : asynchronous active-low reset
//     bus        : audio_framer_if.slave (sample input, frame output)
//     dbg_state  : current FSM state (0 IDLE, 1 PREFETCH, 2 STREAM)
module audio_framer #(
  parameter int FRAME_LEN   = 256,
  parameter int HOP         = 128,
  parameter int ALPHA_SHIFT = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  audio_framer_if.slave  bus,
  output logic [1:0]     dbg_state
);
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int AW    = IDX_W + 1;
  localparam int HOP_W = $clog2(HOP + 1);
  localparam int DEPTH = 2 * FRAME_LEN;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREFETCH = 2'd1;
  localparam logic [1:0] S_STREAM   = 2'd2;

  logic [15:0] mem [DEPTH];

  logic signed [15:0] x_prev_q, x_prev_d;
  logic [15:0]        pe_q, pe_d;
  logic               pe_valid_q, pe_valid_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      sample_cnt_q, sample_cnt_d;
  logic [HOP_W-1:0]   hop_cnt_q, hop_cnt_d;
  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic               pend_q, pend_d;
  logic [15:0]        drop_q, drop_d;

  logic signed [17:0] x_ext, prev_ext, pe_sum;
  logic               wr_en, due, abort, accept;

  // Pre-emphasis stage. 18 bits hold the full range of x - x_prev plus the
  // scaled term, so saturation can be decided on the exact result.
  always_comb begin
    x_ext      = {{2{bus.sample_in[15]}}, bus.sample_in};
    prev_ext   = {{2{x_prev_q[15]}}, x_prev_q};
    pe_sum     = x_ext - prev_ext + (prev_ext >>> ALPHA_SHIFT);
    x_prev_d   = x_prev_q;
    pe_d       = pe_q;
    pe_valid_d = bus.sample_valid;
    if (bus.sample_valid) begin
      x_prev_d = bus.sample_in;
      if (pe_sum > 18'sd32767)       pe_d = 16'h7FFF;
      else if (pe_sum < -18'sd32768) pe_d = 16'h8000;
      else                           pe_d = pe_sum[15:0];
    end
  end

  // Write side: buffer write, pointer and frame-due detection. The first
  // frame is due on write FRAME_LEN; after that hop_cnt counts writes since
  // the last due frame.
  always_comb begin
    wr_en        = pe_valid_q;
    due          = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    sample_cnt_d = sample_cnt_q;
    hop_cnt_d    = hop_cnt_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (sample_cnt_q != AW'(FRAME_LEN)) begin
        sample_cnt_d = sample_cnt_q + AW'(1);
        due          = (sample_cnt_q == AW'(FRAME_LEN - 1));
      end else if (hop_cnt_q == HOP_W'(HOP - 1)) begin
        due       = 1'b1;
        hop_cnt_d = '0;
      end else begin
        hop_cnt_d = hop_cnt_q + HOP_W'(1);
      end
    end
  end

  // rd_ptr always points at the next sample not yet loaded into the output
  // register. Overwriting it loses data, unless the beat on display is the
  // last one, in which case nothing unread remains.
  always_comb begin
    accept = valid_q && bus.frame_ready;
    abort  = wr_en && (wr_ptr_q == rd_ptr_q) &&
             ((state_q == S_PREFETCH) || ((state_q == S_STREAM) && !last_q));
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    err_d    = 1'b0;
    pend_d   = pend_q;
    drop_d   = drop_q;
    case (state_q)
      S_IDLE: begin
        if (due || pend_q) begin
          // A pending frame was due on an earlier write, so wr_ptr_q is
          // already past it; a fresh due frame includes this cycle's write.
          rd_ptr_d = (due ? wr_ptr_d : wr_ptr_q) - AW'(FRAME_LEN);
          pend_d   = 1'b0;
          state_d  = S_PREFETCH;
        end
      end
      S_PREFETCH, S_STREAM: begin
        if (abort) begin
          // Abort beats a simultaneous due frame, which is kept for IDLE.
          err_d   = 1'b1;
          valid_d = 1'b0;
          last_d  = 1'b0;
          pend_d  = due;
          state_d = S_IDLE;
        end else begin
          if (due && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
          if (state_q == S_PREFETCH) begin
            data_d   = mem[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
            idx_d    = '0;
            last_d   = 1'b0;
            valid_d  = 1'b1;
            state_d  = S_STREAM;
          end else if (accept) begin
            if (last_q) begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              data_d   = mem[rd_ptr_q];
              rd_ptr_d = rd_ptr_q + AW'(1);
              idx_d    = idx_q + IDX_W'(1);
              last_d   = (idx_q == IDX_W'(FRAME_LEN - 2));
            end
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev_q     <= '0;
      pe_q         <= '0;
      pe_valid_q   <= 1'b0;
      wr_ptr_q     <= '0;
      sample_cnt_q <= '0;
      hop_cnt_q    <= '0;
      state_q      <= S_IDLE;
      rd_ptr_q     <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      pend_q       <= 1'b0;
      drop_q       <= '0;
    end else begin
      x_prev_q     <= x_prev_d;
      pe_q         <= pe_d;
      pe_valid_q   <= pe_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      sample_cnt_q <= sample_cnt_d;
      hop_cnt_q    <= hop_cnt_d;
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      err_q        <= err_d;
      pend_q       <= pend_d;
      drop_q       <= drop_d;
    end
  end

  // Buffer storage has no reset; its contents are only read after a full
  // frame has been written since reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= pe_q;
  end

  assign bus.frame_data  = data_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_index = idx_q;
  assign bus.frame_last  = last_q;
  assign bus.frame_err   = err_q;
  assign bus.drop_count  = drop_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_audio_framer.sv
// tb_audio_framer
//   Directed-vector bench for audio_framer with FRAME_LEN=8, HOP=4,
//   ALPHA_SHIFT=5. Ramp stimulus uses x[n] = 64*n, whose pre-emphasised
//   value is y[n] = 64 + 2*(n-1) = 62 + 2*n for every n >= 1.
module tb_audio_framer;
  localparam int FL = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         t_last = 0;

  // monitor capture
  logic [15:0] cap_data[$];
  logic [2:0]  cap_idx[$];
  logic        cap_last[$];
  int          rise_q[$];
  int          err_q[$];
  int          last_hi_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] exp_q[$];

  audio_framer_if #(.FRAME_LEN(FL)) bus ();

  audio_framer #(.FRAME_LEN(FL), .HOP(4), .ALPHA_SHIFT(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_valid && !prev_valid) rise_q.push_back(cyc);
      if (bus.frame_valid && bus.frame_ready) begin
        cap_data.push_back(bus.frame_data);
        cap_idx.push_back(bus.frame_index);
        cap_last.push_back(bus.frame_last);
      end
      if (bus.frame_err) err_q.push_back(cyc);
      if (bus.frame_last) last_hi_cnt++;
    end
    prev_valid = bus.frame_valid;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_capture();
    cap_data.delete();
    cap_idx.delete();
    cap_last.delete();
    rise_q.delete();
    err_q.delete();
    exp_q.delete();
    last_hi_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.sample_in = '0;
    bus.sample_valid = 1'b0;
    bus.frame_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_capture();
    step();
  endtask

  // Drives one sample for one cycle, then `gap` idle cycles.
  task automatic send_sample(input logic [15:0] x, input int gap);
    bus.sample_in = x;
    bus.sample_valid = 1'b1;
    t_last = cyc;
    step();
    bus.sample_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cap_data.size() >= n) break;
      step();
    end
    ok = (cap_data.size() >= n);
  endtask

  // scenario tasks
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b expected 0", bus.frame_valid); end
    n_vec++; if (bus.frame_last !== 1'b0) begin n_err++; $display("FAIL rst_last: got %0b expected 0", bus.frame_last); end
    n_vec++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %0b expected 0", bus.frame_err); end
    n_vec++; if (bus.frame_data !== 16'd0) begin n_err++; $display("FAIL rst_data: got %0d expected 0", bus.frame_data); end
    n_vec++; if (bus.frame_index !== 3'd0) begin n_err++; $display("FAIL rst_index: got %0d expected 0", bus.frame_index); end
    n_vec++; if (bus.drop_count !== 16'd0) begin n_err++; $display("FAIL rst_drop: got %0d expected 0", bus.drop_count); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    step();
  endtask

  task automatic test_preemph();
    logic [15:0] xs [2] = '{16'd1000, 16'hFC18};
    logic [15:0] ys [2] = '{16'd31, 16'hFFE0};
    bit ok;
    for (int p = 0; p < 2; p++) begin
      do_reset();
      for (int i = 0; i < FL; i++) begin
        send_sample(xs[p], 0);
        exp_q.push_back(i == 0 ? xs[p] : ys[p]);
      end
      wait_beats(FL, 40, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL preemph_timeout: got %0d beats expected %0d", cap_data.size(), FL); end
      for (int i = 0; i < FL; i++) begin
        n_vec++;
        if (i >= cap_data.size() || cap_data[i] !== exp_q[i] || cap_idx[i] !== 3'(i) || cap_last[i] !== (i == FL - 1)) begin
          n_err++;
          $display("FAIL preemph_beat p%0d i%0d: got %0d expected %0d", p, i,
                   (i < cap_data.size()) ? $signed(cap_data[i]) : -99999, $signed(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] xs [2][FL] = '{'{16'h8000, 16'h7FFF, 0, 0, 0, 0, 0, 0},
                                '{16'h7FFF, 16'h8000, 0, 0, 0, 0, 0, 0}};
    logic [15:0] ys [2][FL] = '{'{16'h8000, 16'h7FFF, 16'h8400, 0, 0, 0, 0, 0},
                                '{16'h7FFF, 16'h8000, 16'h7C00, 0, 0, 0, 0, 0}};
    bit ok;
    for (int p = 0; p < 2; p++) begin
      do_reset();
      for (int i = 0; i < FL; i++) send_sample(xs[p][i], 0);
      wait_beats(FL, 40, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL sat_timeout: got %0d beats expected %0d", cap_data.size(), FL); end
      for (int i = 0; i < FL; i++) begin
        n_vec++;
        if (i >= cap_data.size() || cap_data[i] !== ys[p][i]) begin
          n_err++;
          $display("FAIL sat_beat p%0d i%0d: got %0d expected %0d", p, i,
                   (i < cap_data.size()) ? $signed(cap_data[i]) : -99999, $signed(ys[p][i]));
        end
      end
    end
  endtask

  task automatic test_framing();
    int t_due [3];
    bit ok;
    logic [15:0] e;
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      send_sample(16'(64 * n), 19);
      if (n == 8)  t_due[0] = t_last;
      if (n == 12) t_due[1] = t_last;
      if (n == 16) t_due[2] = t_last;
    end
    wait_beats(3 * FL, 60, ok);
    n_vec++; if (!ok || rise_q.size() != 3) begin n_err++; $display("FAIL frame_count: got %0d starts expected 3", rise_q.size()); end
    for (int f = 0; f < 3; f++) begin
      n_vec++;
      if (f >= rise_q.size() || rise_q[f] != t_due[f] + 3) begin
        n_err++;
        $display("FAIL frame_latency f%0d: got cycle %0d expected %0d", f,
                 (f < rise_q.size()) ? rise_q[f] : -1, t_due[f] + 3);
      end
      for (int i = 0; i < FL; i++) begin
        e = 16'(62 + 2 * (4 * f + i + 1));
        n_vec++;
        if ((f * FL + i) >= cap_data.size() || cap_data[f * FL + i] !== e ||
            cap_idx[f * FL + i] !== 3'(i) || cap_last[f * FL + i] !== (i == FL - 1)) begin
          n_err++;
          $display("FAIL frame_beat f%0d i%0d: got %0d expected %0d", f, i,
                   ((f * FL + i) < cap_data.size()) ? cap_data[f * FL + i] : 16'hFFFF, e);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int  n_acc = 0;
    bit  tog = 1'b0;
    logic [15:0] e;
    do_reset();
    bus.frame_ready = 1'b0;
    for (int n = 1; n <= FL; n++) send_sample(16'(64 * n), 0);
    for (int c = 0; c < 60 && n_acc < FL; c++) begin
      bus.frame_ready = tog;
      tog = !tog;
      @(negedge clk);
      if (bus.frame_valid) begin
        e = 16'(62 + 2 * (n_acc + 1));
        n_vec++;
        if (bus.frame_data !== e || bus.frame_index !== 3'(n_acc) || bus.frame_last !== (n_acc == FL - 1)) begin
          n_err++;
          $display("FAIL bp_beat n%0d: got data %0d idx %0d expected data %0d idx %0d",
                   n_acc, bus.frame_data, bus.frame_index, e, n_acc);
        end
        if (bus.frame_ready) n_acc++;
      end
      step();
    end
    bus.frame_ready = 1'b1;
    n_vec++; if (n_acc != FL) begin n_err++; $display("FAIL bp_count: got %0d beats expected %0d", n_acc, FL); end
    repeat (4) step();
    @(negedge clk);
    n_vec++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL bp_extra: got valid %0b expected 0", bus.frame_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    for (int n = 1; n <= 16; n++) send_sample(16'(64 * n), 0);
    wait_beats(FL, 40, ok);
    repeat (10) step();
    n_vec++; if (cap_data.size() != FL) begin n_err++; $display("FAIL b2b_beats: got %0d expected %0d", cap_data.size(), FL); end
    n_vec++; if (bus.drop_count !== 16'd2) begin n_err++; $display("FAIL b2b_drop: got %0d expected 2", bus.drop_count); end
    n_vec++; if (err_q.size() != 0) begin n_err++; $display("FAIL b2b_err: got %0d pulses expected 0", err_q.size()); end
    for (int i = 0; i < FL; i++) begin
      n_vec++;
      if (i >= cap_data.size() || cap_data[i] !== 16'(62 + 2 * (i + 1))) begin
        n_err++;
        $display("FAIL b2b_beat i%0d: got %0d expected %0d", i,
                 (i < cap_data.size()) ? cap_data[i] : 16'hFFFF, 62 + 2 * (i + 1));
      end
    end
  endtask

  task automatic test_drop_abort();
    int t18 = 0;
    int t20 = 0;
    bit ok;
    do_reset();
    bus.frame_ready = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 13) begin
        n_vec++; if (bus.drop_count !== 16'd1) begin n_err++; $display("FAIL drop_first: got %0d expected 1", bus.drop_count); end
      end
      if (n == 17) begin
        n_vec++; if (bus.drop_count !== 16'd2) begin n_err++; $display("FAIL drop_second: got %0d expected 2", bus.drop_count); end
      end
      send_sample(16'(64 * n), (n == 20) ? 0 : 7);
      if (n == 18) t18 = t_last;
      if (n == 20) t20 = t_last;
    end
    n_vec++; if (err_q.size() != 1 || err_q[0] != t18 + 2) begin
      n_err++; $display("FAIL abort_pulse: got %0d pulses first at %0d expected 1 at %0d",
                        err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, t18 + 2);
    end
    n_vec++; if (last_hi_cnt != 0 || cap_data.size() != 0) begin
      n_err++; $display("FAIL abort_partial: got last %0d beats %0d expected 0 0", last_hi_cnt, cap_data.size());
    end
    bus.frame_ready = 1'b1;
    wait_beats(FL, 30, ok);
    n_vec++; if (rise_q.size() != 2 || rise_q[1] != t20 + 3) begin
      n_err++; $display("FAIL recover_start: got %0d starts last at %0d expected 2 at %0d",
                        rise_q.size(), (rise_q.size() > 0) ? rise_q[rise_q.size() - 1] : -1, t20 + 3);
    end
    for (int i = 0; i < FL; i++) begin
      n_vec++;
      if (i >= cap_data.size() || cap_data[i] !== 16'(62 + 2 * (13 + i)) ||
          cap_idx[i] !== 3'(i) || cap_last[i] !== (i == FL - 1)) begin
        n_err++;
        $display("FAIL recover_beat i%0d: got %0d expected %0d", i,
                 (i < cap_data.size()) ? cap_data[i] : 16'hFFFF, 62 + 2 * (13 + i));
      end
    end
    n_vec++; if (bus.drop_count !== 16'd2) begin n_err++; $display("FAIL drop_final: got %0d expected 2", bus.drop_count); end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    bit ok;
    do_reset();
    bus.frame_ready = 1'b0;
    for (int n = 1; n <= 12; n++) send_sample(16'(64 * n), 0);
    repeat (2) step();
    n_vec++; if (bus.drop_count !== 16'd1) begin n_err++; $display("FAIL mid_predrop: got %0d expected 1", bus.drop_count); end
    bus.frame_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.frame_valid && bus.frame_index == 3'd3) begin hit = 1'b1; break; end
    end
    n_vec++; if (!hit) begin n_err++; $display("FAIL mid_beat3: got no beat 3 expected beat 3 within 30 cycles"); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %0b expected 0", bus.frame_valid); end
    n_vec++; if (bus.drop_count !== 16'd0) begin n_err++; $display("FAIL mid_drop: got %0d expected 0", bus.drop_count); end
    n_vec++; if (bus.frame_index !== 3'd0 || bus.frame_data !== 16'd0) begin
      n_err++; $display("FAIL mid_outs: got idx %0d data %0d expected 0 0", bus.frame_index, bus.frame_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_capture();
    for (int n = 1; n < FL; n++) send_sample(16'(64 * n), 0);
    repeat (10) step();
    n_vec++; if (rise_q.size() != 0) begin n_err++; $display("FAIL mid_early: got %0d starts expected 0", rise_q.size()); end
    send_sample(16'(64 * FL), 0);
    wait_beats(FL, 30, ok);
    n_vec++; if (rise_q.size() != 1 || rise_q[0] != t_last + 3) begin
      n_err++; $display("FAIL mid_restart: got %0d starts at %0d expected 1 at %0d",
                        rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1, t_last + 3);
    end
    for (int i = 0; i < FL; i++) begin
      n_vec++;
      if (i >= cap_data.size() || cap_data[i] !== 16'(62 + 2 * (i + 1))) begin
        n_err++;
        $display("FAIL mid_beat i%0d: got %0d expected %0d", i,
                 (i < cap_data.size()) ? cap_data[i] : 16'hFFFF, 62 + 2 * (i + 1));
      end
    end
  endtask

  // sequence + final report
  initial begin
    bus.sample_in = '0;
    bus.sample_valid = 1'b0;
    bus.frame_ready = 1'b1;
    test_reset();
    test_preemph();
    test_saturation();
    test_framing();
    test_backpressure();
    test_back_to_back();
    test_drop_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
